bmp_to_video_stream_8bit: RTL and testbench



---
 rtl/bmp_video_pkg.sv | 34 +++
 rtl/bmp_to_video_stream_8bit_if.sv | 29 ++
 rtl/video_timing_gen.sv | 73 +++++++
 rtl/bmp_to_video_stream_8bit.sv | 187 ++++++++++++++++++
 tb/tb_bmp_to_video_stream_8bit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bmp_video_pkg.sv
// Shared constants, FSM state type and luma helper for the BMP video source.
// The BMP image is presented as a flat byte array of BMP_MEM_BYTES bytes.
package bmp_video_pkg;

    localparam int unsigned HDR_OFFSET_POS = 10;
    localparam int unsigned HDR_WIDTH_POS  = 18;
    localparam int unsigned HDR_HEIGHT_POS = 22;
    localparam int unsigned HDR_BPP_POS    = 28;

    localparam logic [15:0] BPP_8  = 16'd8;
    localparam logic [15:0] BPP_24 = 16'd24;

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    localparam int unsigned BMP_MEM_BYTES = 4096;
    localparam int unsigned BMP_AW        = 12;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    // Weights sum to 256, so the 16-bit sum never overflows.
    function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
        logic [15:0] s;
        s = LUMA_R * {8'h00, r} + LUMA_G * {8'h00, g} + LUMA_B * {8'h00, b};
        return s[15:8];
    endfunction

endpackage

// File: rtl/bmp_to_video_stream_8bit_if.sv
// Video stream bus plus the BMP byte image feeding the source.
interface bmp_to_video_stream_8bit_if;
    import bmp_video_pkg::*;

    logic        vout_begin;
    logic        vout_vsync;
    logic        vout_hsync;
    logic [7:0]  vout_dat;
    logic        vout_valid;
    logic        vout_done;
    logic [15:0] vout_xres;
    logic [15:0] vout_yres;

    logic        bmp_present;
    logic [7:0]  bmp_mem [BMP_MEM_BYTES];

    modport master (
        input  vout_begin, bmp_present, bmp_mem,
        output vout_vsync, vout_hsync, vout_dat, vout_valid, vout_done,
               vout_xres, vout_yres
    );

    modport slave (
        output vout_begin, bmp_present, bmp_mem,
        input  vout_vsync, vout_hsync, vout_dat, vout_valid, vout_done,
               vout_xres, vout_yres
    );

endinterface

// File: rtl/video_timing_gen.sv
// Raster h/v counters with combinational sync, active-window and x/y decode.
// Counters are held at zero while i_en is low.
module video_timing_gen #(
    parameter int unsigned H_SYNC  = 128,
    parameter int unsigned H_BACK  = 88,
    parameter int unsigned H_DISP  = 800,
    parameter int unsigned H_FRONT = 40,
    parameter int unsigned H_TOTAL = 1056,
    parameter int unsigned V_SYNC  = 4,
    parameter int unsigned V_BACK  = 23,
    parameter int unsigned V_DISP  = 600,
    parameter int unsigned V_FRONT = 1,
    parameter int unsigned V_TOTAL = 628
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_active,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_last
);

    localparam int unsigned H_ACT_BEG = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_END = H_ACT_BEG + H_DISP;
    localparam int unsigned V_ACT_BEG = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_END = V_ACT_BEG + V_DISP;

    if (H_TOTAL != H_ACT_END + H_FRONT) begin : g_bad_h_total
        $error("video_timing_gen: H_TOTAL must equal the sum of the horizontal fields");
    end
    if (V_TOTAL != V_ACT_END + V_FRONT) begin : g_bad_v_total
        $error("video_timing_gen: V_TOTAL must equal the sum of the vertical fields");
    end

    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_h_act;
    logic        w_v_act;

    assign w_h_wrap = (r_h_cnt == 16'(H_TOTAL - 1));
    assign w_v_wrap = (r_v_cnt == 16'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 16'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 16'd1;
        end
    end

    assign w_h_act  = (r_h_cnt >= 16'(H_ACT_BEG)) && (r_h_cnt < 16'(H_ACT_END));
    assign w_v_act  = (r_v_cnt >= 16'(V_ACT_BEG)) && (r_v_cnt < 16'(V_ACT_END));

    assign o_hsync  = (r_h_cnt < 16'(H_SYNC));
    assign o_vsync  = (r_v_cnt < 16'(V_SYNC));
    assign o_active = w_h_act && w_v_act;
    assign o_x      = r_h_cnt - 16'(H_ACT_BEG);
    assign o_y      = r_v_cnt - 16'(V_ACT_BEG);
    assign o_last   = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/bmp_to_video_stream_8bit.sv
// Streams one frame of an 8/24-bpp BMP image as 8-bit raster video per start edge.
// Header fields are latched in LOAD; pixel bytes are fetched live during RUN.
module bmp_to_video_stream_8bit
    import bmp_video_pkg::*;
#(
    parameter int unsigned H_SYNC  = 128,
    parameter int unsigned H_BACK  = 88,
    parameter int unsigned H_DISP  = 800,
    parameter int unsigned H_FRONT = 40,
    parameter int unsigned H_TOTAL = 1056,
    parameter int unsigned V_SYNC  = 4,
    parameter int unsigned V_BACK  = 23,
    parameter int unsigned V_DISP  = 600,
    parameter int unsigned V_FRONT = 1,
    parameter int unsigned V_TOTAL = 628
) (
    input  logic                        clk,
    input  logic                        rst_n,
    bmp_to_video_stream_8bit_if.master  vout
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_begin_q;
    logic        r_done;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_valid;
    logic [7:0]  r_dat;
    logic [15:0] r_xres;
    logic [15:0] r_yres;
    logic [31:0] r_offset;
    logic [31:0] r_row_bytes;
    logic        r_bpp24;
    logic        r_bottom_up;

    logic        w_begin_rise;
    logic        w_run;
    logic [31:0] w_hdr_offset;
    logic [31:0] w_hdr_width;
    logic [31:0] w_hdr_height;
    logic [15:0] w_hdr_bpp;
    logic [31:0] w_abs_height;
    logic [31:0] w_row_raw;
    logic [31:0] w_row_bytes;
    logic        w_hdr_ok;

    logic        w_hs;
    logic        w_vs;
    logic        w_active;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic        w_last;

    logic [31:0] w_row;
    logic [31:0] w_addr0;
    logic [31:0] w_addr1;
    logic [31:0] w_addr2;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_pix;
    logic        w_pix_valid;

    video_timing_gen #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .H_TOTAL(H_TOTAL),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT),
        .V_TOTAL(V_TOTAL)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_run),
        .o_hsync (w_hs),
        .o_vsync (w_vs),
        .o_active(w_active),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_last  (w_last)
    );

    assign w_begin_rise = vout.vout_begin & ~r_begin_q;
    assign w_run        = (r_state == RUN);

    // Little-endian header fields
    assign w_hdr_offset = {vout.bmp_mem[HDR_OFFSET_POS + 3], vout.bmp_mem[HDR_OFFSET_POS + 2],
                           vout.bmp_mem[HDR_OFFSET_POS + 1], vout.bmp_mem[HDR_OFFSET_POS]};
    assign w_hdr_width  = {vout.bmp_mem[HDR_WIDTH_POS + 3], vout.bmp_mem[HDR_WIDTH_POS + 2],
                           vout.bmp_mem[HDR_WIDTH_POS + 1], vout.bmp_mem[HDR_WIDTH_POS]};
    assign w_hdr_height = {vout.bmp_mem[HDR_HEIGHT_POS + 3], vout.bmp_mem[HDR_HEIGHT_POS + 2],
                           vout.bmp_mem[HDR_HEIGHT_POS + 1], vout.bmp_mem[HDR_HEIGHT_POS]};
    assign w_hdr_bpp    = {vout.bmp_mem[HDR_BPP_POS + 1], vout.bmp_mem[HDR_BPP_POS]};

    assign w_abs_height = w_hdr_height[31] ? (~w_hdr_height + 32'd1) : w_hdr_height;
    assign w_row_raw    = (w_hdr_bpp == BPP_24) ? (w_hdr_width * 32'd3) : w_hdr_width;
    assign w_row_bytes  = (w_row_raw + 32'd3) & ~32'd3;
    assign w_hdr_ok     = vout.bmp_present
                        && ((w_hdr_bpp == BPP_8) || (w_hdr_bpp == BPP_24))
                        && (w_hdr_width[31:16] == 16'h0000)
                        && (w_abs_height[31:16] == 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_begin_rise) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = w_hdr_ok ? RUN : IDLE;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bottom-up files store the last displayed line first
    always_comb begin
        w_row   = r_bottom_up ? {16'h0000, r_yres - 16'd1 - w_y} : {16'h0000, w_y};
        w_addr0 = r_offset + w_row * r_row_bytes
                + (r_bpp24 ? ({16'h0000, w_x} * 32'd3) : {16'h0000, w_x});
        w_addr1 = w_addr0 + 32'd1;
        w_addr2 = w_addr0 + 32'd2;
        w_b0    = (w_addr0 < 32'(BMP_MEM_BYTES)) ? vout.bmp_mem[w_addr0[BMP_AW-1:0]] : '0;
        w_b1    = (w_addr1 < 32'(BMP_MEM_BYTES)) ? vout.bmp_mem[w_addr1[BMP_AW-1:0]] : '0;
        w_b2    = (w_addr2 < 32'(BMP_MEM_BYTES)) ? vout.bmp_mem[w_addr2[BMP_AW-1:0]] : '0;
        w_pix   = r_bpp24 ? luma8(w_b2, w_b1, w_b0) : w_b0;
        w_pix_valid = w_run && w_active && (w_x < r_xres) && (w_y < r_yres);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_begin_q   <= 1'b0;
            r_done      <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_valid     <= 1'b0;
            r_dat       <= '0;
            r_xres      <= '0;
            r_yres      <= '0;
            r_offset    <= '0;
            r_row_bytes <= '0;
            r_bpp24     <= 1'b0;
            r_bottom_up <= 1'b0;
        end else begin
            r_begin_q <= vout.vout_begin;
            if (r_state == LOAD) begin
                if (w_hdr_ok) begin
                    r_offset    <= w_hdr_offset;
                    r_row_bytes <= w_row_bytes;
                    r_bpp24     <= (w_hdr_bpp == BPP_24);
                    r_bottom_up <= ~w_hdr_height[31];
                    r_xres      <= w_hdr_width[15:0];
                    r_yres      <= w_abs_height[15:0];
                    r_done      <= 1'b0;
                end else begin
                    r_done      <= 1'b1;
                end
            end else if (w_run && w_last) begin
                r_done <= 1'b1;
            end
            r_hsync <= w_run & w_hs;
            r_vsync <= w_run & w_vs;
            r_valid <= w_pix_valid;
            r_dat   <= w_pix_valid ? w_pix : '0;
        end
    end

    assign vout.vout_hsync = r_hsync;
    assign vout.vout_vsync = r_vsync;
    assign vout.vout_valid = r_valid;
    assign vout.vout_dat   = r_dat;
    assign vout.vout_done  = r_done;
    assign vout.vout_xres  = r_xres;
    assign vout.vout_yres  = r_yres;

endmodule

// File: tb/tb_bmp_to_video_stream_8bit.sv
// Directed bench: tiny raster timing, small hand-built BMP images, fixed expected streams.
module tb_bmp_to_video_stream_8bit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bmp_to_video_stream_8bit_if vif ();

    bmp_to_video_stream_8bit #(
        .H_SYNC (2),
        .H_BACK (2),
        .H_DISP (4),
        .H_FRONT(2),
        .H_TOTAL(10),
        .V_SYNC (1),
        .V_BACK (1),
        .V_DISP (3),
        .V_FRONT(1),
        .V_TOTAL(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vout (vif.master)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    int         nbeat;
    logic [7:0] beat_dat [16];
    int         beat_cyc [16];
    int         hs_cnt, vs_cnt, vs_first, bad_valid, dat_leak, done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put32(input int a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) vif.bmp_mem[a + k] = v[8*k +: 8];
    endtask

    task automatic bmp_header(input int offset, input int w, input int h, input int bpp);
        logic [31:0] b;
        b = 32'(bpp);
        for (int i = 0; i < 4096; i++) vif.bmp_mem[i] = 8'h00;
        vif.bmp_mem[0] = 8'h42;
        vif.bmp_mem[1] = 8'h4D;
        put32(10, 32'(offset));
        put32(18, 32'(w));
        put32(22, 32'(h));
        vif.bmp_mem[28] = b[7:0];
        vif.bmp_mem[29] = b[15:8];
        vif.bmp_present = 1'b1;
    endtask

    // 4x3, 8 bpp, bottom-up; display pixel (x,y) = 4*y + x
    task automatic load_img1();
        bmp_header(64, 4, 3, 8);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                vif.bmp_mem[64 + (2 - y) * 4 + x] = 8'(4 * y + x);
    endtask

    task automatic pix24(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
        vif.bmp_mem[54 + (1 - y) * 12 + 3 * x]     = b;
        vif.bmp_mem[54 + (1 - y) * 12 + 3 * x + 1] = g;
        vif.bmp_mem[54 + (1 - y) * 12 + 3 * x + 2] = r;
    endtask

    // Drives a start at the current negedge and records 80 cycles of output.
    task automatic capture(input int pulse_at);
        nbeat = 0; hs_cnt = 0; vs_cnt = 0; vs_first = -1;
        bad_valid = 0; dat_leak = 0; done_cyc = 0;
        vif.vout_begin = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 4) vif.vout_begin = 1'b0;
            if (pulse_at > 0 && c == pulse_at)     vif.vout_begin = 1'b1;
            if (pulse_at > 0 && c == pulse_at + 2) vif.vout_begin = 1'b0;
            if (vif.vout_valid === 1'b1) begin
                if (nbeat < 16) begin
                    beat_dat[nbeat] = vif.vout_dat;
                    beat_cyc[nbeat] = c;
                end
                nbeat++;
                if (vif.vout_hsync === 1'b1 || vif.vout_vsync === 1'b1) bad_valid++;
            end else if (vif.vout_dat !== 8'h00) begin
                dat_leak++;
            end
            if (vif.vout_hsync === 1'b1) hs_cnt++;
            if (vif.vout_vsync === 1'b1) begin
                if (vs_first < 0) vs_first = c;
                vs_cnt++;
            end
            if (c >= 2 && done_cyc == 0 && vif.vout_done === 1'b1) done_cyc = c;
        end
    endtask

    task automatic check_img1(input string p);
        check({p, "_xres"}, 32'(vif.vout_xres), 4);
        check({p, "_yres"}, 32'(vif.vout_yres), 3);
        check({p, "_nbeat"}, nbeat, 12);
        check({p, "_done_cyc"}, done_cyc, 62);
        check({p, "_hs_cnt"}, hs_cnt, 12);
        check({p, "_vs_cnt"}, vs_cnt, 10);
        check({p, "_vs_first"}, vs_first, 3);
        check({p, "_valid_in_sync"}, bad_valid, 0);
        check({p, "_dat_leak"}, dat_leak, 0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_beat%0d_dat", p, i), 32'(beat_dat[i]), i);
            check($sformatf("%s_beat%0d_cyc", p, i), beat_cyc[i], 27 + 10 * (i / 4) + i % 4);
        end
    endtask

    int exp24 [6] = '{76, 149, 28, 255, 18, 0};
    int exp3  [4] = '{100, 101, 110, 111};
    int cyc3  [4] = '{27, 28, 37, 38};

    initial begin
        rst_n = 1'b0;
        vif.vout_begin  = 1'b0;
        vif.bmp_present = 1'b0;
        for (int i = 0; i < 4096; i++) vif.bmp_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hsync", 32'(vif.vout_hsync), 0);
        check("rst_vsync", 32'(vif.vout_vsync), 0);
        check("rst_valid", 32'(vif.vout_valid), 0);
        check("rst_dat",   32'(vif.vout_dat), 0);
        check("rst_done",  32'(vif.vout_done), 0);
        check("rst_xres",  32'(vif.vout_xres), 0);
        check("rst_yres",  32'(vif.vout_yres), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Missing file
        capture(0);
        check("nofile_done_cyc", done_cyc, 2);
        check("nofile_nbeat", nbeat, 0);
        check("nofile_hs_cnt", hs_cnt, 0);
        check("nofile_xres", 32'(vif.vout_xres), 0);
        check("nofile_yres", 32'(vif.vout_yres), 0);

        // 4x3 8 bpp frame with an extra start edge during RUN
        load_img1();
        @(negedge clk);
        capture(20);
        check_img1("img8");

        // Unsupported bpp keeps the previous resolution
        bmp_header(64, 2, 2, 16);
        @(negedge clk);
        capture(0);
        check("bpp16_done_cyc", done_cyc, 2);
        check("bpp16_nbeat", nbeat, 0);
        check("bpp16_xres", 32'(vif.vout_xres), 4);

        // 3x2, 24 bpp, rows padded from 9 to 12 bytes
        bmp_header(54, 3, 2, 24);
        for (int i = 54; i < 78; i++) vif.bmp_mem[i] = 8'hEE;
        pix24(0, 0, 8'd255, 8'd0,   8'd0);
        pix24(1, 0, 8'd0,   8'd255, 8'd0);
        pix24(2, 0, 8'd0,   8'd0,   8'd255);
        pix24(0, 1, 8'd255, 8'd255, 8'd255);
        pix24(1, 1, 8'd10,  8'd20,  8'd30);
        pix24(2, 1, 8'd0,   8'd0,   8'd0);
        @(negedge clk);
        capture(0);
        check("img24_xres", 32'(vif.vout_xres), 3);
        check("img24_yres", 32'(vif.vout_yres), 2);
        check("img24_nbeat", nbeat, 6);
        check("img24_done_cyc", done_cyc, 62);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("img24_beat%0d_dat", i), 32'(beat_dat[i]), 32'(exp24[i]));
            check($sformatf("img24_beat%0d_cyc", i), beat_cyc[i], 27 + 10 * (i / 3) + i % 3);
        end

        // 2x2, 8 bpp, top-down (negative height), padding bytes hold junk
        bmp_header(64, 2, -2, 8);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 2; x++) vif.bmp_mem[64 + y * 4 + x] = 8'(100 + 10 * y + x);
            vif.bmp_mem[64 + y * 4 + 2] = 8'hAA;
            vif.bmp_mem[64 + y * 4 + 3] = 8'hAA;
        end
        @(negedge clk);
        capture(0);
        check("img2x2_xres", 32'(vif.vout_xres), 2);
        check("img2x2_yres", 32'(vif.vout_yres), 2);
        check("img2x2_nbeat", nbeat, 4);
        check("img2x2_dat_leak", dat_leak, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("img2x2_beat%0d_dat", i), 32'(beat_dat[i]), 32'(exp3[i]));
            check($sformatf("img2x2_beat%0d_cyc", i), beat_cyc[i], 32'(cyc3[i]));
        end

        // Reset in the middle of an active line, then replay the frame
        load_img1();
        @(negedge clk);
        vif.vout_begin = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 4) vif.vout_begin = 1'b0;
        end
        check("mid_valid_before_rst", 32'(vif.vout_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_hsync", 32'(vif.vout_hsync), 0);
        check("midrst_vsync", 32'(vif.vout_vsync), 0);
        check("midrst_valid", 32'(vif.vout_valid), 0);
        check("midrst_dat",   32'(vif.vout_dat), 0);
        check("midrst_done",  32'(vif.vout_done), 0);
        check("midrst_xres",  32'(vif.vout_xres), 0);
        check("midrst_yres",  32'(vif.vout_yres), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        capture(0);
        check_img1("replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
